// File: rtl/ctrl_fsm_sequencer.sv
// rtl/ctrl_fsm_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb sequencer for the control decoder
module ctrl_fsm_sequencer #(
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic               imem_req,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir,
    input  logic               dec_halt,
    input  logic               dec_reg_write,
    input  logic               dec_mem_write,
    input  logic               dec_sel_wb,
    input  logic               dec_jump,
    input  logic               dec_branch,
    input  logic               br_taken,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ack,
    output logic               pc_we,
    output logic               pc_sel_target,
    output logic               rf_we,
    output logic               halted,
    output logic               bus_err,
    output logic [2:0]         state_o,
    output logic [CNT_W-1:0]   instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam bit              WD_EN   = (TIMEOUT > 0);
    localparam int              WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_EN ? TIMEOUT - 1 : 0);

    state_t             r_state;
    logic [INSTR_W-1:0] r_ir;
    logic [CNT_W-1:0]   r_cnt;
    logic [WD_W-1:0]    r_wd;

    logic w_wd_expire;
    logic w_mem_op;

    assign w_wd_expire = WD_EN && (r_wd == WD_LAST);
    assign w_mem_op    = dec_mem_write | dec_sel_wb;

    // Watchdog only counts while waiting on a memory; it is cleared on every entry to FETCH/MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_wd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state <= S_FETCH;
                        r_wd    <= '0;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_DECODE;
                    end else if (w_wd_expire) begin
                        r_state <= S_ERR;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                S_DECODE: begin
                    r_state <= dec_halt ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    if (w_mem_op) begin
                        r_state <= S_MEM;
                        r_wd    <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_state <= S_WB;
                    end else if (w_wd_expire) begin
                        r_state <= S_ERR;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                S_WB: begin
                    if (~&r_cnt) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (run) begin
                        r_state <= S_FETCH;
                        r_wd    <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                S_ERR:   r_state <= S_ERR;
                default: r_state <= S_ERR;
            endcase
        end
    end

    // Strobes are decoded from state so WB is the only cycle that can touch PC/RF.
    assign imem_req      = (r_state == S_FETCH);
    assign dmem_req      = (r_state == S_MEM);
    assign dmem_we       = (r_state == S_MEM) & dec_mem_write;
    assign pc_we         = (r_state == S_WB);
    assign pc_sel_target = (r_state == S_WB) & (dec_jump | (dec_branch & br_taken));
    assign rf_we         = (r_state == S_WB) & dec_reg_write;
    assign halted        = (r_state == S_HALT);
    assign bus_err       = (r_state == S_ERR);
    assign state_o       = r_state;
    assign ir            = r_ir;
    assign instr_cnt     = r_cnt;

endmodule

// File: tb/tb_ctrl_fsm_sequencer.sv
// tb/tb_ctrl_fsm_sequencer.sv - randomized self-checking bench for ctrl_fsm_sequencer
module tb_ctrl_fsm_sequencer;

    localparam int TMO = 4;
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_ERR  = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n, run, imem_ack, dmem_ack, br_taken;
    logic [15:0] imem_rdata;
    logic        dec_halt, dec_reg_write, dec_mem_write, dec_sel_wb, dec_jump, dec_branch;
    logic        imem_req, dmem_req, dmem_we, pc_we, pc_sel_target, rf_we, halted, bus_err;
    logic [15:0] ir;
    logic [2:0]  state_o;
    logic [3:0]  instr_cnt;

    always #5 clk = ~clk;

    ctrl_fsm_sequencer #(.INSTR_W(16), .CNT_W(4), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir),
        .dec_halt(dec_halt), .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
        .dec_sel_wb(dec_sel_wb), .dec_jump(dec_jump), .dec_branch(dec_branch), .br_taken(br_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc_we(pc_we), .pc_sel_target(pc_sel_target), .rf_we(rf_we),
        .halted(halted), .bus_err(bus_err), .state_o(state_o), .instr_cnt(instr_cnt)
    );

    typedef struct {
        logic        run, iack, halt, rw, mw, sw, jp, br, tk, dack;
        logic [15:0] idata;
        logic [2:0]  st;
        logic        ireq, dreq, dwe, pcwe, pcsel, rfwe, hlt, berr;
        logic [15:0] ir;
        logic [3:0]  cnt;
    } rec_t;

    rec_t        exp_q[$];
    int          n_chk = 0, n_err = 0;
    int          pcwe_seen = 0, rfwe_seen = 0, last_fetch = 0;
    logic [15:0] m_ir = '0;
    logic [3:0]  m_cnt = '0;
    logic [2:0]  m_st = S_IDLE;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Expected record for one cycle in a given state; inputs that state ignores are randomized.
    function automatic rec_t base(input logic [2:0] st);
        rec_t r;
        r.run = 1'($urandom); r.iack = 1'($urandom); r.dack = 1'($urandom);
        r.halt = 1'($urandom); r.rw = 1'($urandom); r.mw = 1'($urandom); r.sw = 1'($urandom);
        r.jp = 1'($urandom); r.br = 1'($urandom); r.tk = 1'($urandom);
        r.idata = 16'($urandom);
        r.st = st;
        r.ireq = 0; r.dreq = 0; r.dwe = 0; r.pcwe = 0; r.pcsel = 0; r.rfwe = 0;
        r.hlt = (st == S_HALT); r.berr = (st == S_ERR);
        r.ir = m_ir; r.cnt = m_cnt;
        return r;
    endfunction

    function automatic rec_t fl(input rec_t ri, input logic h, rw, mw, sw, jp, br, tk);
        rec_t r = ri;
        r.halt = h; r.rw = rw; r.mw = mw; r.sw = sw; r.jp = jp; r.br = br; r.tk = tk;
        return r;
    endfunction

    task automatic cyc(input rec_t r);
        @(posedge clk);
        #1;
        run = r.run; imem_ack = r.iack; imem_rdata = r.idata; dmem_ack = r.dack;
        dec_halt = r.halt; dec_reg_write = r.rw; dec_mem_write = r.mw; dec_sel_wb = r.sw;
        dec_jump = r.jp; dec_branch = r.br; br_taken = r.tk;
        exp_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            rec_t e;
            e = exp_q.pop_front();
            chk("state_o", state_o, e.st);
            chk("strobes{ireq,dreq,dwe,pcwe,pcsel,rfwe,hlt,berr}",
                {imem_req, dmem_req, dmem_we, pc_we, pc_sel_target, rf_we, halted, bus_err},
                {e.ireq, e.dreq, e.dwe, e.pcwe, e.pcsel, e.rfwe, e.hlt, e.berr});
            chk("ir", ir, e.ir);
            chk("instr_cnt", instr_cnt, e.cnt);
            if (pc_we) pcwe_seen++;
            if (rf_we) rfwe_seen++;
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_outs"}, {imem_req, dmem_req, dmem_we, pc_we, pc_sel_target, rf_we, halted, bus_err}, 0);
        chk({nm, "_state"}, state_o, 0);
        chk({nm, "_ir"}, ir, 0);
        chk({nm, "_cnt"}, instr_cnt, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        chk("pre_reset_state", state_o, m_st);
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        chk_reset_outs("async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_st = S_IDLE; m_ir = '0; m_cnt = '0;
    endtask

    task automatic stay(input logic [2:0] st, input int n);
        rec_t r;
        repeat (n) begin
            r = base(st);
            r.run = 1'b1;
            cyc(r);
        end
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 jump, 4 branch, 5 halt
    task automatic run_instr(input int kind, input int wf, input int wd, input bit run_wb,
                             input bit abort_mem, input logic tk);
        rec_t        r;
        logic [15:0] op;
        logic        h, rw, mw, sw, jp, br;
        op = 16'($urandom);
        h = 0; rw = 0; mw = 0; sw = 0; jp = 0; br = 0;
        case (kind)
            0:       rw = 1;
            1:       begin sw = 1; rw = 1; end
            2:       mw = 1;
            3:       begin jp = 1; rw = 1'($urandom); end
            4:       br = 1;
            default: h = 1;
        endcase
        if (m_st == S_IDLE) begin
            repeat ($urandom_range(0, 2)) begin
                r = base(S_IDLE); r.run = 1'b0; cyc(r);
            end
            r = base(S_IDLE); r.run = 1'b1; cyc(r);
            m_st = S_FETCH;
        end
        last_fetch = 0;
        for (int j = 0; j <= wf; j++) begin
            r = base(S_FETCH);
            r.ireq = 1'b1;
            r.iack = (j == wf);
            if (r.iack) r.idata = op;
            cyc(r);
            last_fetch++;
            if (!r.iack && j == TMO - 1) begin
                m_st = S_ERR;
                return;
            end
        end
        m_ir = op;
        cyc(fl(base(S_DECODE), h, rw, mw, sw, jp, br, tk));
        if (h) begin
            m_st = S_HALT;
            return;
        end
        cyc(fl(base(S_EXEC), h, rw, mw, sw, jp, br, tk));
        if (mw | sw) begin
            for (int j = 0; j <= wd; j++) begin
                r = fl(base(S_MEM), h, rw, mw, sw, jp, br, tk);
                r.dreq = 1'b1; r.dwe = mw; r.dack = (j == wd);
                cyc(r);
                if (abort_mem && j == 1) begin
                    m_st = S_MEM;
                    return;
                end
                if (!r.dack && j == TMO - 1) begin
                    m_st = S_ERR;
                    return;
                end
            end
        end
        r = fl(base(S_WB), h, rw, mw, sw, jp, br, tk);
        r.run = run_wb; r.pcwe = 1'b1; r.rfwe = rw; r.pcsel = jp | (br & tk);
        cyc(r);
        if (m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
        m_st = run_wb ? S_FETCH : S_IDLE;
    endtask

    initial begin
        int p0, r0;
        rst_n = 1'b0; run = 1'b0; imem_ack = 0; dmem_ack = 0; br_taken = 0; imem_rdata = '0;
        dec_halt = 0; dec_reg_write = 0; dec_mem_write = 0; dec_sel_wb = 0; dec_jump = 0; dec_branch = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("power_on_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        repeat (3) run_instr(0, 0, 0, 1, 0, 1'b0);
        sync();
        chk("start_pcwe_pulses", pcwe_seen, 3);
        chk("start_model_cnt", m_cnt, 3);

        r0 = rfwe_seen;
        run_instr(1, 0, 3, 1, 0, 1'b0);
        sync();
        chk("load_rfwe_once", rfwe_seen - r0, 1);

        run_instr(4, 0, 0, 1, 0, 1'b1);
        run_instr(4, 1, 0, 1, 0, 1'b0);
        run_instr(2, 2, 2, 0, 0, 1'b0);

        run_instr(5, 0, 0, 1, 0, 1'b0);
        p0 = pcwe_seen;
        stay(S_HALT, 20);
        sync();
        chk("halt_no_pcwe", pcwe_seen - p0, 0);
        chk("halt_flag", halted, 1);
        do_reset();

        run_instr(0, 6, 0, 1, 0, 1'b0);
        chk("tmo_fetch_cycles", last_fetch, 4);
        stay(S_ERR, 3);
        sync();
        chk("tmo_bus_err", bus_err, 1);
        do_reset();
        run_instr(0, 3, 0, 1, 0, 1'b0);
        chk("ack_4th_fetch_cycles", last_fetch, 4);
        chk("ack_4th_no_err", (m_st == S_ERR), 0);

        run_instr(2, 0, 3, 1, 1, 1'b0);
        do_reset();

        repeat (18) run_instr(0, 0, 0, 1, 0, 1'b0);
        chk("sat_model_cnt", m_cnt, 15);
        run_instr(3, 0, 0, 1, 0, 1'b0);
        do_reset();

        for (int i = 0; i < 80; i++) begin
            int k, wf, wd;
            k  = ($urandom_range(0, 19) == 0) ? 5 : $urandom_range(0, 4);
            wf = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3);
            wd = ($urandom_range(0, 9) == 0) ? 5 : $urandom_range(0, 3);
            run_instr(k, wf, wd, 1'($urandom), 0, 1'($urandom));
            if (m_st == S_HALT || m_st == S_ERR) begin
                stay(m_st, 3);
                do_reset();
            end
        end

        sync();
        sync();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
